// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: paces conversion requests on a fixed period, averages
// 2^LOG2_N completed samples and watchdogs each conversion for a lost completion.
module adc_sample_sequencer #(
   parameter int unsigned CLK_DIV = 50000,
   parameter int unsigned LOG2_N  = 3,
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned DATA_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              start_tx,
   input  logic              done_pulse,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   output logic              busy,
   output logic              timeout_err
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned ACC_W = DATA_W + LOG2_N;
   localparam int unsigned CNT_W = LOG2_N + 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      REQ,
      WAIT_DONE,
      OUTPUT
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [DIV_W-1:0]  r_div;
   logic [WD_W-1:0]   r_wd;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_avg;
   logic              r_terr;

   logic              w_tick;
   logic              w_accept;
   logic              w_last;
   logic              w_expire;
   logic [ACC_W-1:0]  w_acc_sum;

   assign w_tick    = enable && (r_div == DIV_LAST);
   assign w_accept  = enable && (r_state == WAIT_DONE) && done_pulse;
   assign w_last    = w_accept && (r_cnt == CNT_LAST);
   assign w_expire  = enable && (r_state == WAIT_DONE) && !done_pulse && (r_wd == WD_LAST);
   assign w_acc_sum = r_acc + ACC_W'(adc_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div <= '0;
      end else if (!enable || (r_div == DIV_LAST)) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (!enable) begin
         w_next = IDLE;
      end else begin
         unique case (r_state)
            IDLE:      w_next = WAIT_TICK;
            WAIT_TICK: if (w_tick) w_next = REQ;
            REQ:       w_next = WAIT_DONE;
            WAIT_DONE: begin
               if (w_accept) begin
                  w_next = w_last ? OUTPUT : WAIT_TICK;
               end else if (w_expire) begin
                  w_next = WAIT_TICK;
               end
            end
            OUTPUT:    w_next = WAIT_TICK;
            default:   w_next = IDLE;
         endcase
      end
   end

   always_comb begin
      start_tx    = (r_state == REQ);
      busy        = (r_state == WAIT_DONE);
      avg_valid   = (r_state == OUTPUT);
      avg_out     = r_avg;
      timeout_err = r_terr;
   end

   // Watchdog counts WAIT_DONE cycles; expiry fires on the TIMEOUT-th such cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wd <= '0;
      end else if (!enable || (r_state == REQ)) begin
         r_wd <= '0;
      end else if (r_state == WAIT_DONE) begin
         r_wd <= r_wd + WD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (!enable || (r_state == OUTPUT)) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_acc_sum;
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // The average is loaded with the final sample so avg_out already carries the
   // new value during the OUTPUT cycle that raises avg_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_avg <= '0;
      end else if (w_last) begin
         r_avg <= w_acc_sum[ACC_W-1:LOG2_N];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_terr <= 1'b0;
      end else if (!enable) begin
         r_terr <= 1'b0;
      end else if (w_expire) begin
         r_terr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: responds to start_tx like an ADC controller,
// predicts averages and request timing from the sampling rules, scoreboards avg_valid.
module tb_adc_sample_sequencer;

   localparam int CLK_DIV = 10;
   localparam int LOG2_N  = 2;
   localparam int TIMEOUT = 20;
   localparam int DATA_W  = 8;
   localparam int NS      = 1 << LOG2_N;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b0;
   logic              done_pulse = 1'b0;
   logic [DATA_W-1:0] adc_data = '0;
   logic              start_tx;
   logic [DATA_W-1:0] avg_out;
   logic              avg_valid;
   logic              busy;
   logic              timeout_err;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int val;
      int cycle;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   samples[$];
   int   exp_start = -1;
   int   exp_terr = 0;
   int   last_avg = 0;

   adc_sample_sequencer #(
      .CLK_DIV(CLK_DIV),
      .LOG2_N (LOG2_N),
      .TIMEOUT(TIMEOUT),
      .DATA_W (DATA_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .start_tx   (start_tx),
      .done_pulse (done_pulse),
      .adc_data   (adc_data),
      .avg_out    (avg_out),
      .avg_valid  (avg_valid),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every avg_valid must match the oldest predicted average.
   always @(negedge clk) begin
      if (reset && avg_valid) begin
         if (sb.size() == 0) begin
            check("avg_valid with empty scoreboard", avg_valid, 0);
         end else begin
            e_mon = sb.pop_front();
            check("avg_out value", avg_out, e_mon.val);
            check("avg_valid cycle", cyc, e_mon.cycle);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(output int s);
      s = -1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (start_tx) begin
            s = cyc;
            break;
         end
      end
      if (s < 0) check("start_tx within cycle budget", start_tx, 1);
   endtask

   // One conversion: answer start_tx after d cycles (d=0 or d>TIMEOUT means no
   // accepted answer; d=TIMEOUT+1 sends a late, ignored done_pulse).
   task automatic conv(input int d, input int data);
      int s, last_i, free, sum, acc_ok, busy_ok;
      wait_start(s);
      if (s < 0) return;
      check("start_tx cycle", s, exp_start);
      check("timeout_err sticky state", timeout_err, exp_terr);
      check("avg_out held", avg_out, last_avg);
      acc_ok  = (d >= 1 && d <= TIMEOUT) ? 1 : 0;
      last_i  = acc_ok ? d : TIMEOUT + 1;
      busy_ok = 1;
      for (int i = 1; i <= last_i; i++) begin
         step();
         if (i <= TIMEOUT && !busy) busy_ok = 0;
         if (i == d) begin
            done_pulse = 1'b1;
            adc_data   = DATA_W'(data);
         end
         if (i == TIMEOUT + 1) begin
            check("busy after watchdog expiry", busy, 0);
            check("timeout_err after expiry", timeout_err, 1);
         end
      end
      step();
      done_pulse = 1'b0;
      adc_data   = DATA_W'($urandom);
      check("busy throughout conversion", busy_ok, 1);
      if (acc_ok) begin
         check("busy drops after done", busy, 0);
         samples.push_back(data);
         if (samples.size() == NS) begin
            sum = 0;
            foreach (samples[k]) sum += samples[k];
            sb.push_back('{sum / NS, s + d + 1});
            last_avg = sum / NS;
            samples.delete();
            free = s + d + 2;
         end else begin
            free = s + d + 1;
         end
      end else begin
         exp_terr = 1;
         free = s + TIMEOUT + 1;
      end
      // next request follows the first tick seen while waiting, tick = cycle before start
      exp_start = s + CLK_DIV * ((free - s + CLK_DIV) / CLK_DIV);
   endtask

   task automatic inject_idle_done();
      step();
      check("busy low at injected done", busy, 0);
      done_pulse = 1'b1;
      adc_data   = 8'd200;
      step();
      done_pulse = 1'b0;
   endtask

   task automatic abort_in_flight();
      int s;
      wait_start(s);
      if (s < 0) return;
      check("start_tx cycle before abort", s, exp_start);
      step();
      step();
      check("busy before abort", busy, 1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("busy after abort", busy, 0);
      check("start_tx after abort", start_tx, 0);
      check("timeout_err cleared by enable", timeout_err, 0);
      check("avg_out held through abort", avg_out, last_avg);
      samples.delete();
      exp_terr  = 0;
      enable    = 1'b1;
      exp_start = cyc + CLK_DIV;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int seen, d;

      // reset and disabled idle
      repeat (3) step();
      check("reset avg_out", avg_out, 0);
      check("reset avg_valid", avg_valid, 0);
      check("reset start_tx", start_tx, 0);
      check("reset busy", busy, 0);
      check("reset timeout_err", timeout_err, 0);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (start_tx) seen = 1;
      end
      check("no start_tx while disabled", seen, 0);

      enable    = 1'b1;
      exp_start = cyc + CLK_DIV;
      conv(5, 10);
      conv(5, 20);
      conv(5, 30);
      conv(5, 40);

      for (int i = 0; i < 4; i++) conv(5, 255);
      conv(5, 1);
      conv(5, 1);
      conv(5, 1);
      conv(5, 2);

      // timeout, then samples keep averaging
      conv(0, 0);
      for (int i = 0; i < 4; i++) conv(int'($urandom_range(1, 7)), int'($urandom_range(0, 255)));

      // abort mid-group
      conv(4, 100);
      conv(4, 100);
      abort_in_flight();
      for (int i = 0; i < 4; i++) conv(4, 8);

      // ignored done in WAIT_TICK, dropped tick, expiry boundary, late done
      conv(3, 50);
      inject_idle_done();
      conv(12, 60);
      conv(TIMEOUT, 70);
      conv(TIMEOUT + 1, 99);
      conv(2, 80);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, TIMEOUT + 1));
         else d = int'($urandom_range(1, 8));
         conv(d, int'($urandom_range(0, 255)));
      end

      while (samples.size() != 0) conv(2, 200);
      for (int i = 0; i < 4; i++) conv(2, 200);
      step();
      check("scoreboard drained", sb.size(), 0);

      // asynchronous reset mid-run
      reset = 1'b0;
      #2;
      check("async reset avg_out", avg_out, 0);
      check("async reset busy", busy, 0);
      check("async reset timeout_err", timeout_err, 0);
      check("async reset start_tx", start_tx, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
